// File: rtl/zbt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : zbt_arbiter
// Description : Shares one pipelined ZBT SRAM among three requesters with
//               fixed priority: display reader (read-only, highest), NTSC
//               capture writer (write-only, via a small FIFO) and a
//               frame-processing port (read/write, request/grant, lowest).
//               At most one memory operation is issued per cycle; read data
//               is routed back to the requester that issued it, in order.
// Ports       : clk/reset            - clock, synchronous active-high reset
//               disp_*               - display read request / returned data
//               ntsc_*               - NTSC write strobe, overflow flag
//               fifo_level           - NTSC FIFO occupancy (registered)
//               proc_*               - processor request/grant, read return
//               mem_*                - ZBT address, write enable, write data,
//                                      read data
// Revision    : 1.0 - initial release
// ============================================================================
module zbt_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int LAT        = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          disp_req,
    input  logic [18:0]                   disp_addr,
    output logic [35:0]                   disp_data,
    output logic                          disp_valid,
    input  logic                          ntsc_we,
    input  logic [18:0]                   ntsc_addr,
    input  logic [35:0]                   ntsc_data,
    output logic                          ntsc_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          proc_req,
    input  logic                          proc_we,
    input  logic [18:0]                   proc_addr,
    input  logic [35:0]                   proc_wdata,
    output logic                          proc_gnt,
    output logic [35:0]                   proc_rdata,
    output logic                          proc_rvalid,
    output logic [18:0]                   mem_addr,
    output logic                          mem_we,
    output logic [35:0]                   mem_wdata,
    input  logic [35:0]                   mem_rdata
);

    localparam int                 c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int                 c_lvl_w   = c_ptr_w + 1;
    localparam logic [c_lvl_w-1:0] c_depth   = c_lvl_w'(FIFO_DEPTH);
    localparam logic [c_lvl_w-1:0] c_lvl_one = c_lvl_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    // ------------------------------------------------------------------
    // NTSC FIFO state
    // ------------------------------------------------------------------
    logic [18:0]        fifo_addr_q [FIFO_DEPTH];
    logic [35:0]        fifo_data_q [FIFO_DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_lvl_w-1:0] count_q, count_d;
    logic               ovf_q, ovf_d;

    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic               w_fifo_push;
    logic               w_fifo_pop;

    // ------------------------------------------------------------------
    // Arbitration result for the current cycle
    // ------------------------------------------------------------------
    logic               w_sel_disp;
    logic               w_sel_ntsc;
    logic               w_sel_proc;
    logic               w_issue_v;
    logic               w_issue_we;
    logic [18:0]        w_issue_addr;
    logic [35:0]        w_issue_wdata;

    // ------------------------------------------------------------------
    // Issue register, write-data pipeline, read tag pipeline, returns
    // ------------------------------------------------------------------
    logic [18:0]        mem_addr_q, mem_addr_d;
    logic               mem_we_q, mem_we_d;
    logic [35:0]        mem_wdata_q, mem_wdata_d;
    logic               proc_gnt_q, proc_gnt_d;

    // Bit k of the tag pipeline belongs to the read whose address is k
    // cycles old; owner bit set means the processor port issued it.
    logic [LAT:0]       tag_v_q, tag_v_d;
    logic [LAT:0]       tag_own_q, tag_own_d;

    logic [LAT-1:0]     wd_v_q, wd_v_d;
    logic [35:0]        wd_data_q [LAT];
    logic [35:0]        wd_data_d [LAT];

    logic               disp_valid_q, disp_valid_d;
    logic [35:0]        disp_data_q, disp_data_d;
    logic               proc_rvalid_q, proc_rvalid_d;
    logic [35:0]        proc_rdata_q, proc_rdata_d;

    // ------------------------------------------------------------------
    // Arbitration and FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        w_fifo_empty  = (count_q == '0);
        w_fifo_full   = (count_q == c_depth);

        w_sel_disp    = disp_req;
        w_sel_ntsc    = !disp_req && !w_fifo_empty;
        // The grant pulse masks the still-held request for one cycle so a
        // single request is never issued twice.
        w_sel_proc    = !disp_req && w_fifo_empty && proc_req && !proc_gnt_q;

        w_issue_v     = w_sel_disp || w_sel_ntsc || w_sel_proc;
        w_issue_we    = w_sel_ntsc || (w_sel_proc && proc_we);
        w_issue_addr  = proc_addr;
        w_issue_wdata = proc_wdata;
        if (w_sel_disp) begin
            w_issue_addr = disp_addr;
        end else if (w_sel_ntsc) begin
            w_issue_addr  = fifo_addr_q[rd_ptr_q];
            w_issue_wdata = fifo_data_q[rd_ptr_q];
        end

        // A same-cycle pop frees a slot, so a full FIFO still accepts.
        w_fifo_pop    = w_sel_ntsc;
        w_fifo_push   = ntsc_we && (!w_fifo_full || w_fifo_pop);
        ovf_d         = ovf_q || (ntsc_we && w_fifo_full && !w_fifo_pop);

        wr_ptr_d      = w_fifo_push ? wr_ptr_q + c_ptr_one : wr_ptr_q;
        rd_ptr_d      = w_fifo_pop  ? rd_ptr_q + c_ptr_one : rd_ptr_q;
        count_d       = count_q;
        if (w_fifo_push && !w_fifo_pop) begin
            count_d = count_q + c_lvl_one;
        end else if (!w_fifo_push && w_fifo_pop) begin
            count_d = count_q - c_lvl_one;
        end
    end

    // ------------------------------------------------------------------
    // Memory pins, pipelines and read return routing
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr_d    = w_issue_v ? w_issue_addr : mem_addr_q;
        mem_we_d      = w_issue_v && w_issue_we;
        proc_gnt_d    = w_sel_proc;

        tag_v_d       = {tag_v_q[LAT-1:0], (w_issue_v && !w_issue_we)};
        tag_own_d     = {tag_own_q[LAT-1:0], w_sel_proc};

        wd_v_d[0]     = w_issue_v && w_issue_we;
        wd_data_d[0]  = w_issue_wdata;
        for (int k = 1; k < LAT; k++) begin
            wd_v_d[k]    = wd_v_q[k-1];
            wd_data_d[k] = wd_data_q[k-1];
        end

        // The last write-data stage lands on the pins LAT cycles after
        // its address; otherwise the pins keep their previous value.
        mem_wdata_d   = wd_v_q[LAT-1] ? wd_data_q[LAT-1] : mem_wdata_q;

        // mem_rdata in this cycle belongs to the read at tag stage LAT.
        disp_valid_d  = tag_v_q[LAT] && !tag_own_q[LAT];
        proc_rvalid_d = tag_v_q[LAT] &&  tag_own_q[LAT];
        disp_data_d   = disp_valid_d  ? mem_rdata : disp_data_q;
        proc_rdata_d  = proc_rvalid_d ? mem_rdata : proc_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            proc_gnt_q    <= 1'b0;
            tag_v_q       <= '0;
            tag_own_q     <= '0;
            wd_v_q        <= '0;
            for (int k = 0; k < LAT; k++) begin
                wd_data_q[k] <= '0;
            end
            disp_valid_q  <= 1'b0;
            disp_data_q   <= '0;
            proc_rvalid_q <= 1'b0;
            proc_rdata_q  <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ovf_q         <= ovf_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            proc_gnt_q    <= proc_gnt_d;
            tag_v_q       <= tag_v_d;
            tag_own_q     <= tag_own_d;
            wd_v_q        <= wd_v_d;
            wd_data_q     <= wd_data_d;
            disp_valid_q  <= disp_valid_d;
            disp_data_q   <= disp_data_d;
            proc_rvalid_q <= proc_rvalid_d;
            proc_rdata_q  <= proc_rdata_d;
        end
    end

    // FIFO storage needs no reset: occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_fifo_push) begin
            fifo_addr_q[wr_ptr_q] <= ntsc_addr;
            fifo_data_q[wr_ptr_q] <= ntsc_data;
        end
    end

    assign disp_data     = disp_data_q;
    assign disp_valid    = disp_valid_q;
    assign ntsc_overflow = ovf_q;
    assign fifo_level    = count_q;
    assign proc_gnt      = proc_gnt_q;
    assign proc_rdata    = proc_rdata_q;
    assign proc_rvalid   = proc_rvalid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_we        = mem_we_q;
    assign mem_wdata     = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_zbt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_zbt_arbiter
// Description : Self-checking bench for zbt_arbiter. A cycle-indexed model
//               records which operation each cycle issues and derives every
//               output from that history; directed sequences add literal
//               checks for the key latencies and corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zbt_arbiter;

    localparam int c_lat   = 2;
    localparam int c_depth = 4;
    localparam int c_hist  = 4096;
    localparam int OWN_NONE = 0;
    localparam int OWN_DISP = 1;
    localparam int OWN_NTSC = 2;
    localparam int OWN_PROC = 3;

    logic        clk;
    logic        reset;
    logic        disp_req;
    logic [18:0] disp_addr;
    logic [35:0] disp_data;
    logic        disp_valid;
    logic        ntsc_we;
    logic [18:0] ntsc_addr;
    logic [35:0] ntsc_data;
    logic        ntsc_overflow;
    logic [2:0]  fifo_level;
    logic        proc_req;
    logic        proc_we;
    logic [18:0] proc_addr;
    logic [35:0] proc_wdata;
    logic        proc_gnt;
    logic [35:0] proc_rdata;
    logic        proc_rvalid;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [35:0] mem_wdata;
    logic [35:0] mem_rdata;

    zbt_arbiter #(.FIFO_DEPTH(c_depth), .LAT(c_lat)) dut (
        .clk          (clk),
        .reset        (reset),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_data    (disp_data),
        .disp_valid   (disp_valid),
        .ntsc_we      (ntsc_we),
        .ntsc_addr    (ntsc_addr),
        .ntsc_data    (ntsc_data),
        .ntsc_overflow(ntsc_overflow),
        .fifo_level   (fifo_level),
        .proc_req     (proc_req),
        .proc_we      (proc_we),
        .proc_addr    (proc_addr),
        .proc_wdata   (proc_wdata),
        .proc_gnt     (proc_gnt),
        .proc_rdata   (proc_rdata),
        .proc_rvalid  (proc_rvalid),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Read data pattern: unique per cycle so misrouted or reordered data shows.
    function automatic logic [35:0] pat(input int c);
        logic [15:0] lo;
        lo = c[15:0];
        return {20'hC0DE5, lo};
    endfunction

    int          cyc = 0;
    bit          force_en = 1'b0;
    logic [35:0] force_val = '0;

    always @(negedge clk) begin
        mem_rdata = force_en ? force_val : pat(cyc);
    end

    // ------------------------------------------------------------------
    // Model: history of the operation issued in each cycle
    // ------------------------------------------------------------------
    typedef struct {
        logic [18:0] a;
        logic [35:0] d;
    } wrd_t;

    wrd_t        fq[$];
    bit          iv   [c_hist];
    bit          iwe  [c_hist];
    int          iown [c_hist];
    logic [18:0] iaddr[c_hist];
    logic [35:0] idata[c_hist];
    int          last_rst = -1;
    bit          armed = 1'b0;

    bit          e_we, e_gnt, e_dv, e_pv, e_ovf;
    logic [18:0] e_addr;
    logic [35:0] e_wdata, e_rd;
    int          e_lvl;

    function automatic bit live(input int i);
        if (i < 0 || i <= last_rst) return 1'b0;
        return iv[i];
    endfunction

    always @(posedge clk) begin : model
        int   cur;
        int   i;
        wrd_t w;
        cur = cyc;
        iv[cur]   = 1'b0;
        iwe[cur]  = 1'b0;
        iown[cur] = OWN_NONE;
        if (reset) begin
            last_rst = cur;
            fq.delete();
            e_ovf = 1'b0; e_addr = '0; e_we = 1'b0; e_wdata = '0;
            e_dv = 1'b0; e_pv = 1'b0; e_gnt = 1'b0; e_lvl = 0;
            armed = 1'b1;
        end else begin
            if (disp_req) begin
                iv[cur] = 1'b1; iwe[cur] = 1'b0; iaddr[cur] = disp_addr; iown[cur] = OWN_DISP;
            end else if (fq.size() != 0) begin
                w = fq.pop_front();
                iv[cur] = 1'b1; iwe[cur] = 1'b1; iaddr[cur] = w.a; idata[cur] = w.d;
                iown[cur] = OWN_NTSC;
            end else if (proc_req && !e_gnt) begin
                iv[cur] = 1'b1; iwe[cur] = proc_we; iaddr[cur] = proc_addr;
                idata[cur] = proc_wdata; iown[cur] = OWN_PROC;
            end
            if (ntsc_we) begin
                if (fq.size() < c_depth) fq.push_back('{ntsc_addr, ntsc_data});
                else e_ovf = 1'b1;
            end
            e_we  = iv[cur] && iwe[cur];
            if (iv[cur]) e_addr = iaddr[cur];
            e_gnt = iv[cur] && (iown[cur] == OWN_PROC);
            i = cur - c_lat;
            if (live(i) && iwe[i]) e_wdata = idata[i];
            i = cur - c_lat - 1;
            e_dv  = live(i) && !iwe[i] && (iown[i] == OWN_DISP);
            e_pv  = live(i) && !iwe[i] && (iown[i] == OWN_PROC);
            e_rd  = mem_rdata;
            e_lvl = fq.size();
        end
        cyc = cur + 1;
    end

    always @(negedge clk) begin
        if (armed) begin
            check("mem_we",        36'(mem_we),        36'(e_we));
            check("mem_addr",      36'(mem_addr),      36'(e_addr));
            check("mem_wdata",     mem_wdata,          e_wdata);
            check("proc_gnt",      36'(proc_gnt),      36'(e_gnt));
            check("disp_valid",    36'(disp_valid),    36'(e_dv));
            check("proc_rvalid",   36'(proc_rvalid),   36'(e_pv));
            check("fifo_level",    36'(fifo_level),    36'(e_lvl));
            check("ntsc_overflow", 36'(ntsc_overflow), 36'(e_ovf));
            if (e_dv) check("disp_data",  disp_data,  e_rd);
            if (e_pv) check("proc_rdata", proc_rdata, e_rd);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        check("rst_mem_addr",    36'(mem_addr),      36'd0);
        check("rst_mem_we",      36'(mem_we),        36'd0);
        check("rst_mem_wdata",   mem_wdata,          36'd0);
        check("rst_disp_valid",  36'(disp_valid),    36'd0);
        check("rst_disp_data",   disp_data,          36'd0);
        check("rst_proc_rvalid", 36'(proc_rvalid),   36'd0);
        check("rst_proc_rdata",  proc_rdata,         36'd0);
        check("rst_proc_gnt",    36'(proc_gnt),      36'd0);
        check("rst_fifo_level",  36'(fifo_level),    36'd0);
        check("rst_overflow",    36'(ntsc_overflow), 36'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int gcyc, gcount, rvcyc, c3;
        reset = 1'b1;
        disp_req = 1'b0; disp_addr = '0;
        ntsc_we = 1'b0; ntsc_addr = '0; ntsc_data = '0;
        proc_req = 1'b0; proc_we = 1'b0; proc_addr = '0; proc_wdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk_reset_state();
        tick();

        // Single display read with a fixed return word
        force_en = 1'b1; force_val = 36'hABCDE0123;
        disp_req = 1'b1; disp_addr = 19'h00010;
        tick();
        disp_req = 1'b0;
        check("t1_mem_addr", 36'(mem_addr), 36'h00010);
        tick(); tick();
        check("t1_no_early_valid", 36'(disp_valid), 36'd0);
        tick();
        check("t1_disp_valid", 36'(disp_valid), 36'd1);
        check("t1_disp_data", disp_data, 36'hABCDE0123);
        check("t1_no_proc_rvalid", 36'(proc_rvalid), 36'd0);
        force_en = 1'b0;
        repeat (2) tick();

        // Single NTSC write while idle
        ntsc_we = 1'b1; ntsc_addr = 19'h12345; ntsc_data = 36'h0FFFF0000;
        tick();
        ntsc_we = 1'b0;
        tick();
        check("t2_mem_we", 36'(mem_we), 36'd1);
        check("t2_mem_addr", 36'(mem_addr), 36'h12345);
        tick(); tick();
        check("t2_mem_wdata", mem_wdata, 36'h0FFFF0000);
        repeat (2) tick();

        // Display hogs the memory; FIFO fills and overflows, then drains
        for (int k = 0; k < 8; k++) begin
            disp_req = 1'b1; disp_addr = 19'h00200 + 19'(k);
            ntsc_we = (k < 6); ntsc_addr = 19'h30000 + 19'(k);
            ntsc_data = 36'h5A5A00000 + 36'(k);
            tick();
            if (k == 3) check("t3_fifo_full_level", 36'(fifo_level), 36'd4);
        end
        check("t3_overflow", 36'(ntsc_overflow), 36'd1);
        check("t3_level_held", 36'(fifo_level), 36'd4);
        disp_req = 1'b0; ntsc_we = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("t3_drain_we", 36'(mem_we), 36'd1);
            check("t3_drain_addr", 36'(mem_addr), 36'h30000 + 36'(j));
        end
        check("t3_drained_level", 36'(fifo_level), 36'd0);
        repeat (4) tick();

        // Processor read waits for display and NTSC traffic to clear
        gcyc = -1; gcount = 0; rvcyc = -1;
        proc_we = 1'b0; proc_addr = 19'h00100; proc_wdata = '0;
        for (int t = 0; t < 20; t++) begin
            proc_req = (gcyc < 0);
            disp_req = (t < 3); disp_addr = 19'h00400 + 19'(t);
            ntsc_we = (t < 3); ntsc_addr = 19'h50000 + 19'(t);
            ntsc_data = 36'h0DEAD0000 + 36'(t);
            tick();
            if (proc_gnt) begin
                gcount++;
                if (gcyc < 0) gcyc = t + 1;
            end
            if (proc_rvalid && rvcyc < 0) rvcyc = t + 1;
        end
        check("t4_gnt_cycle", 36'(gcyc), 36'd7);
        check("t4_gnt_count", 36'(gcount), 36'd1);
        check("t4_rvalid_cycle", 36'(rvcyc), 36'd10);
        proc_req = 1'b0;
        repeat (2) tick();

        // Read / write / read on consecutive issue cycles
        disp_req = 1'b1; disp_addr = 19'h0AAAA;
        proc_req = 1'b1; proc_we = 1'b1; proc_addr = 19'h00200; proc_wdata = 36'h123456789;
        tick();
        disp_req = 1'b0;
        check("t5_we0", 36'(mem_we), 36'd0);
        check("t5_addr0", 36'(mem_addr), 36'h0AAAA);
        tick();
        disp_req = 1'b1; disp_addr = 19'h0BBBB;
        proc_req = 1'b0;
        check("t5_gnt", 36'(proc_gnt), 36'd1);
        check("t5_we1", 36'(mem_we), 36'd1);
        check("t5_addr1", 36'(mem_addr), 36'h00200);
        tick();
        disp_req = 1'b0;
        c3 = cyc;
        check("t5_we2", 36'(mem_we), 36'd0);
        check("t5_addr2", 36'(mem_addr), 36'h0BBBB);
        tick();
        check("t5_wdata", mem_wdata, 36'h123456789);
        check("t5_dv0", 36'(disp_valid), 36'd1);
        check("t5_dd0", disp_data, pat(c3));
        tick();
        check("t5_dv_gap", 36'(disp_valid), 36'd0);
        tick();
        check("t5_dv1", 36'(disp_valid), 36'd1);
        check("t5_dd1", disp_data, pat(c3 + 2));
        repeat (2) tick();

        // Reset two cycles after a display read drops the read
        disp_req = 1'b1; disp_addr = 19'h00077;
        tick();
        disp_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_state();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t6_no_valid", 36'(disp_valid), 36'd0);
        end

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
